// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register stage behind the combinational
// multiplier. A start strobe snapshots the 64-bit product, the unit stays busy
// for a fixed number of cycles, and then commits the snapshot to HI/LO.
// MTHI/MTLO writes and MFHI/MFLO reads are served while idle. Any request made
// while a multiply is in flight raises stall so that upstream holds it.
module hilo_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] productHI,
    input  logic [DATA_W-1:0] productLO,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wrData,
    input  logic              mfhi,
    input  logic              mflo,
    output logic [DATA_W-1:0] rdData,
    output logic              busy,
    output logic              stall,
    output logic [DATA_W-1:0] hiOut,
    output logic [DATA_W-1:0] loOut
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hiloState_t;

    // The counter is loaded with latency-1 so that the commit edge is exactly
    // MULT_LATENCY edges after the accepted start edge.
    localparam logic [3:0] CNT_LOAD = 4'(MULT_LATENCY - 1);

    hiloState_t        state;
    hiloState_t        nextState;
    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;
    logic [DATA_W-1:0] pendHi;
    logic [DATA_W-1:0] pendLo;
    logic [3:0]        cnt;
    logic              anyRequest;

    // State register: reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: leave IDLE on start, return once the countdown hits zero.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start)      nextState = BUSY;
            BUSY: if (cnt == 4'd0) nextState = IDLE;
        endcase
    end

    // Output logic: busy/stall flags and the combinational read port (mfhi wins).
    always_comb begin
        busy       = (state == BUSY);
        anyRequest = start | mthi | mtlo | mfhi | mflo;
        stall      = busy & anyRequest;
        if (mfhi) begin
            rdData = hiReg;
        end else if (mflo) begin
            rdData = loReg;
        end else begin
            rdData = '0;
        end
    end

    // Datapath: snapshot/countdown/commit while busy, MT writes only when idle.
    // A start together with MT writes lets the writes land now; the later
    // commit then overwrites both registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiReg  <= '0;
            loReg  <= '0;
            pendHi <= '0;
            pendLo <= '0;
            cnt    <= 4'd0;
        end else if (state == IDLE) begin
            if (start) begin
                pendHi <= productHI;
                pendLo <= productLO;
                cnt    <= CNT_LOAD;
            end
            if (mthi) begin
                hiReg <= wrData;
            end
            if (mtlo) begin
                loReg <= wrData;
            end
        end else begin
            if (cnt == 4'd0) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign hiOut = hiReg;
    assign loOut = loReg;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: drives two hilo_unit instances (latency 4 and latency 1) with
// the same directed stimulus. A cycle-level model keyed on absolute commit
// times is compared against both instances every cycle, and hand-computed
// literal expectations pin the model at the interesting points.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] productHI = '0;
   logic [31:0] productLO = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wrData = '0;
   logic        mfhi = 1'b0;
   logic        mflo = 1'b0;

   logic [31:0] rd4, hi4, lo4, rd1, hi1, lo1;
   logic        busy4, stall4, busy1, stall1;

   int dirChecks = 0;
   int dirErrors = 0;
   int cmpChecks = 0;
   int cmpErrors = 0;
   int totalChecks = 0;
   int totalErrors = 0;

   // Model state: index 0 is the latency-4 instance, index 1 the latency-1 one.
   int          cycleNo = 0;
   bit          modelValid = 1'b0;
   logic [31:0] mHi[2];
   logic [31:0] mLo[2];
   logic [31:0] mPendHi[2];
   logic [31:0] mPendLo[2];
   int          mCommitAt[2];

   hilo_unit #(.MULT_LATENCY(4), .DATA_W(32)) dut4 (
      .clk(clk), .reset(reset), .start(start),
      .productHI(productHI), .productLO(productLO),
      .mthi(mthi), .mtlo(mtlo), .wrData(wrData),
      .mfhi(mfhi), .mflo(mflo),
      .rdData(rd4), .busy(busy4), .stall(stall4),
      .hiOut(hi4), .loOut(lo4)
   );

   hilo_unit #(.MULT_LATENCY(1), .DATA_W(32)) dut1 (
      .clk(clk), .reset(reset), .start(start),
      .productHI(productHI), .productLO(productLO),
      .mthi(mthi), .mtlo(mtlo), .wrData(wrData),
      .mfhi(mfhi), .mflo(mflo),
      .rdData(rd1), .busy(busy1), .stall(stall1),
      .hiOut(hi1), .loOut(lo1)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic int latOf(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   // Compares one value, counts it, prints a FAIL line on mismatch and reports the outcome.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected, output bit ok);
      ok = (actual === expected);
      totalChecks++;
      if (!ok) begin
         totalErrors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic dirCheck(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
      bit ok;
      checkOutput(name, actual, expected, ok);
      dirChecks++;
      if (!ok) dirErrors++;
   endtask

   task automatic modelCheck(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
      bit ok;
      checkOutput(name, actual, expected, ok);
      cmpChecks++;
      if (!ok) cmpErrors++;
   endtask

   // Sets every input; takes effect at the next rising edge.
   task automatic applyStimulus(input logic rst, input logic st,
                                input logic hiW, input logic loW,
                                input logic rdH, input logic rdL,
                                input logic [31:0] pHi, input logic [31:0] pLo,
                                input logic [31:0] wd);
      reset     = rst;
      start     = st;
      mthi      = hiW;
      mtlo      = loW;
      mfhi      = rdH;
      mflo      = rdL;
      productHI = pHi;
      productLO = pLo;
      wrData    = wd;
   endtask

   task automatic idleInputs();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic stepClock(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model initialisation: nothing pending, HI/LO cleared.
   initial begin
      for (int k = 0; k < 2; k++) begin
         mHi[k] = '0; mLo[k] = '0; mPendHi[k] = '0; mPendLo[k] = '0;
         mCommitAt[k] = -1;
      end
   end

   // Model update: a multiply commits at an absolute edge number fixed when it
   // is accepted; requests are only honoured when nothing is pending.
   always @(posedge clk) begin
      cycleNo <= cycleNo + 1;
      if (reset) modelValid <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            mHi[k]       <= '0;
            mLo[k]       <= '0;
            mPendHi[k]   <= '0;
            mPendLo[k]   <= '0;
            mCommitAt[k] <= -1;
         end else if (mCommitAt[k] >= 0) begin
            if (cycleNo == mCommitAt[k]) begin
               mHi[k]       <= mPendHi[k];
               mLo[k]       <= mPendLo[k];
               mCommitAt[k] <= -1;
            end
         end else begin
            if (start) begin
               mPendHi[k]   <= productHI;
               mPendLo[k]   <= productLO;
               mCommitAt[k] <= cycleNo + latOf(k);
            end
            if (mthi) mHi[k] <= wrData;
            if (mtlo) mLo[k] <= wrData;
         end
      end
   end

   task automatic compareInst(input int k, input logic [31:0] rd, input logic bsy,
                              input logic stl, input logic [31:0] hi, input logic [31:0] lo);
      logic        expBusy;
      logic [31:0] expRd;
      expBusy = (mCommitAt[k] >= 0);
      expRd   = mfhi ? mHi[k] : (mflo ? mLo[k] : 32'h0);
      modelCheck($sformatf("model%0d.hiOut", latOf(k)), hi, mHi[k]);
      modelCheck($sformatf("model%0d.loOut", latOf(k)), lo, mLo[k]);
      modelCheck($sformatf("model%0d.busy", latOf(k)), {31'h0, bsy}, {31'h0, expBusy});
      modelCheck($sformatf("model%0d.stall", latOf(k)), {31'h0, stl},
                 {31'h0, expBusy & (start | mthi | mtlo | mfhi | mflo)});
      modelCheck($sformatf("model%0d.rdData", latOf(k)), rd, expRd);
   endtask

   // Every mid-cycle, both instances are checked against the model.
   always @(negedge clk) begin
      if (modelValid) begin
         compareInst(0, rd4, busy4, stall4, hi4, lo4);
         compareInst(1, rd1, busy1, stall1, hi1, lo1);
      end
   end

   // Directed stimulus sequence following the test plan.
   initial begin
      $display("[TB] starting hilo_unit bench");

      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      stepClock(2);
      dirCheck("reset.hiOut", hi4, 32'h0);
      dirCheck("reset.loOut", lo4, 32'h0);
      dirCheck("reset.busy", {31'h0, busy4}, 32'h0);
      dirCheck("reset.stall", {31'h0, stall4}, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
      #1;
      dirCheck("reset.rdData", rd4, 32'h0);
      stepClock(1);

      applyStimulus(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0);
      stepClock(1);
      idleInputs();
      dirCheck("mul.busyE0", {31'h0, busy4}, 32'h1);
      dirCheck("lat1.busyE0", {31'h0, busy1}, 32'h1);
      stepClock(1);
      dirCheck("mul.busyE1", {31'h0, busy4}, 32'h1);
      dirCheck("lat1.hiE1", hi1, 32'hFFFF_FFFF);
      dirCheck("lat1.loE1", lo1, 32'h0000_0001);
      dirCheck("lat1.busyE1", {31'h0, busy1}, 32'h0);
      stepClock(2);
      dirCheck("mul.busyE3", {31'h0, busy4}, 32'h1);
      dirCheck("mul.hiE3", hi4, 32'h0);
      stepClock(1);
      dirCheck("mul.hiE4", hi4, 32'hFFFF_FFFF);
      dirCheck("mul.loE4", lo4, 32'h0000_0001);
      dirCheck("mul.busyE4", {31'h0, busy4}, 32'h0);

      applyStimulus(0, 1, 0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h0);
      stepClock(1);
      idleInputs();
      stepClock(1);
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h3333_3333, 32'h4444_4444, 32'h0);
      #1;
      dirCheck("stall.flag", {31'h0, stall4}, 32'h1);
      dirCheck("stall.rdData", rd4, 32'h0000_0001);
      stepClock(3);
      dirCheck("stall.firstHi", hi4, 32'h1111_1111);
      dirCheck("stall.firstLo", lo4, 32'h2222_2222);
      dirCheck("stall.idleBusy", {31'h0, busy4}, 32'h0);
      dirCheck("stall.idleStall", {31'h0, stall4}, 32'h0);
      stepClock(1);
      idleInputs();
      dirCheck("stall.accepted", {31'h0, busy4}, 32'h1);
      stepClock(3);
      dirCheck("stall.preHi", hi4, 32'h1111_1111);
      stepClock(1);
      dirCheck("stall.secondHi", hi4, 32'h3333_3333);
      dirCheck("stall.secondLo", lo4, 32'h4444_4444);

      applyStimulus(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h1234_5678);
      stepClock(1);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h9ABC_DEF0);
      stepClock(1);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
      #1;
      dirCheck("mf.both", rd4, 32'h1234_5678);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
      #1;
      dirCheck("mf.lo", rd4, 32'h9ABC_DEF0);
      dirCheck("mf.lat1Lo", rd1, 32'h9ABC_DEF0);
      stepClock(1);
      applyStimulus(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 32'hCAFE_F00D);
      stepClock(1);
      idleInputs();
      dirCheck("mt.bothHi", hi4, 32'hCAFE_F00D);
      dirCheck("mt.bothLo", lo4, 32'hCAFE_F00D);

      applyStimulus(0, 1, 0, 0, 0, 0, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0);
      stepClock(1);
      idleInputs();
      stepClock(2);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      stepClock(1);
      idleInputs();
      dirCheck("abort.hi", hi4, 32'h0);
      dirCheck("abort.lo", lo4, 32'h0);
      dirCheck("abort.busy", {31'h0, busy4}, 32'h0);
      stepClock(6);
      dirCheck("abort.hiLater", hi4, 32'h0);
      dirCheck("abort.busyLater", {31'h0, busy4}, 32'h0);

      applyStimulus(0, 1, 1, 0, 0, 0, 32'h0000_0007, 32'h0, 32'h0000_0001);
      stepClock(1);
      dirCheck("simul.hiNow", hi4, 32'h0000_0001);
      dirCheck("simul.busy", {31'h0, busy4}, 32'h1);
      dirCheck("simul.lat1Hi", hi1, 32'h0000_0001);
      applyStimulus(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF);
      stepClock(1);
      idleInputs();
      dirCheck("simul.mtIgnored", hi4, 32'h0000_0001);
      dirCheck("simul.lat1Commit", hi1, 32'h0000_0007);
      stepClock(3);
      dirCheck("simul.commitHi", hi4, 32'h0000_0007);
      dirCheck("simul.commitLo", lo4, 32'h0);
      stepClock(2);

      $display("[TB] Result: errors=%0d of %0d checks", totalErrors, totalChecks);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Architectural HI/LO register stage directly downstream of the combinational unsigned/signed multiplier; consumes its productHI/productLO outputs.
- Snapshots the product on a start strobe, models a fixed multi-cycle multiply latency, then commits to HI/LO.
- Serves MFHI/MFLO reads and MTHI/MTLO writes, and generates a pipeline stall while a multiply is in flight.

Parameters:
- MULT_LATENCY, 4, cycles from the accepted start edge to the HI/LO commit edge; legal range 1..15.
- DATA_W, 32, width of HI, LO and the data ports.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to capture the multiplier result and begin a multiply.
- productHI  input  DATA_W  multiplier result, most significant word.
- productLO  input  DATA_W  multiplier result, least significant word.
- mthi  input  1  write wrData into HI.
- mtlo  input  1  write wrData into LO.
- wrData  input  DATA_W  data for mthi/mtlo.
- mfhi  input  1  read request for HI.
- mflo  input  1  read request for LO.
- rdData  output  DATA_W  read data (combinational).
- busy  output  1  multiply in flight.
- stall  output  1  current request not accepted; upstream holds it.
- hiOut  output  DATA_W  current HI register.
- loOut  output  DATA_W  current LO register.

Behaviour:
- Reset (synchronous, active-high), at the clk edge with reset=1:
  - HI, LO, pendHI, pendLO and cnt are cleared to 0; state goes to IDLE.
  - Result: busy=0, stall=0, hiOut=0, loOut=0, and rdData=0 when no read is requested.
  - Reset wins over every other input. Reset during BUSY aborts the multiply with no commit.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE with start=1, at the edge:
  - pendHI<=productHI and pendLO<=productLO (operands may change after this edge).
  - cnt<=MULT_LATENCY-1; state<=BUSY.
- BUSY, at each edge:
  - cnt==0: HI<=pendHI, LO<=pendLO, state<=IDLE.
  - Otherwise cnt<=cnt-1.
  - New values appear on hiOut/loOut exactly MULT_LATENCY cycles after the start edge. MULT_LATENCY=1 commits on the next edge.
- stall = busy & (start | mthi | mtlo | mfhi | mflo), combinational.
  - While busy, no request is accepted. start, mthi and mtlo have no effect.
  - A start held through the commit cycle is accepted on the first IDLE cycle. There is no back-to-back bypass.
- mthi/mtlo in IDLE: write wrData at the edge.
  - Both asserted together: both HI and LO are written.
  - start, mthi and mtlo together in IDLE: all are honoured. The mt writes land now; the later commit overwrites both HI and LO.
- Read data, combinational and independent of busy:
  - rdData = mfhi ? HI : (mflo ? LO : 0). mfhi has priority when both reads are asserted.
  - The consumer must discard rdData while stall=1.
- The product is treated as a raw 64-bit value. No sign handling is done here; sign correction is the multiplier's job.
- cnt width is 4 bits. cnt never wraps, because it is reloaded only from IDLE.

Test Plan:
- Reset, then idle:
  - Check hiOut=0, loOut=0, busy=0 and stall=0.
  - mfhi=1 -> rdData=0.
- Basic multiply, MULT_LATENCY=4:
  - Stimulus: productHI=0xFFFFFFFF, productLO=0x00000001, start pulse at edge E0; inputs changed to 0 right after E0.
  - Required: busy=1 for edges E1..E4; hiOut=0xFFFFFFFF and loOut=0x00000001 after E4; busy=0 after E4.
- Stall during busy:
  - Stimulus: start again plus mflo=1 at cycle 2 of a multiply.
  - Required: stall=1 and no restart.
  - Start held until IDLE -> accepted on the first IDLE edge; the second result commits 4 edges later.
- MT and MF paths in IDLE:
  - mthi with wrData=0x12345678, then mtlo with wrData=0x9ABCDEF0.
  - mfhi&mflo -> rdData=0x12345678; mflo alone -> 0x9ABCDEF0.
- Reset mid-operation:
  - Stimulus: start with product 0xAAAA5555_5555AAAA, then reset at cnt=1.
  - Required: HI=LO=0, busy=0, and no commit ever occurs.
- Simultaneous start and mthi in IDLE:
  - Stimulus: wrData=0x1, productHI=0x7.
  - Required: hiOut=0x1 after the first edge, then 0x7 after the commit edge.
- MULT_LATENCY=1 variant: commit on the edge after start, with busy high for exactly one cycle.
